// File: rtl/sdlx_pkg.sv
// Shared SDLX definitions: R-type field positions, default R opcode and the
// byte-assembler state encoding.
package sdlx_pkg;
  localparam logic [5:0] OPCODE_R_DEF = 6'b000000;

  localparam int OP_MSB   = 31;
  localparam int OP_LSB   = 26;
  localparam int RS1_MSB  = 25;
  localparam int RS1_LSB  = 21;
  localparam int RS2_MSB  = 20;
  localparam int RS2_LSB  = 16;
  localparam int RD_MSB   = 15;
  localparam int RD_LSB   = 11;
  localparam int FUNC_MSB = 5;
  localparam int FUNC_LSB = 0;

  localparam int NUM_LANES = 4;
  localparam int LANE_W    = 8;

  typedef enum logic {
    COLLECT = 1'b0,
    HOLD    = 1'b1
  } asm_state_e;
endpackage

// File: rtl/ir_field_decode.sv
// Combinational R-type field slicer; shared with the execute stage.
module ir_field_decode
  import sdlx_pkg::*;
#(
  parameter logic [5:0] OPCODE_R = OPCODE_R_DEF
) (
  input  logic [31:0] ir,
  output logic [4:0]  rs1,
  output logic [4:0]  rs2,
  output logic [4:0]  rd,
  output logic [5:0]  alu_ctrl,
  output logic        is_rtype
);
  assign rs1      = ir[RS1_MSB:RS1_LSB];
  assign rs2      = ir[RS2_MSB:RS2_LSB];
  assign rd       = ir[RD_MSB:RD_LSB];
  assign alu_ctrl = ir[FUNC_MSB:FUNC_LSB];
  assign is_rtype = (ir[OP_MSB:OP_LSB] == OPCODE_R);
endmodule

// File: rtl/ir_byte_assembler.sv
// Packs a little-endian byte stream into 32-bit SDLX words and holds each word
// until the execute stage takes it. Partial-word timeout: IR_BYTE_TIMEOUT_EN.
module ir_byte_assembler
  import sdlx_pkg::*;
#(
  parameter logic [5:0] OPCODE_R    = OPCODE_R_DEF,
  parameter int         TIMEOUT_CYC = 16
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [7:0]  byte_in,
  input  logic        byte_valid,
  output logic        byte_ready,
  output logic [3:0]  byte_sel,
  output logic [31:0] ir_out,
  output logic        ir_valid,
  input  logic        ir_ready,
  output logic [4:0]  rs1,
  output logic [4:0]  rs2,
  output logic [4:0]  rd,
  output logic [5:0]  alu_ctrl,
  output logic        is_rtype,
  output logic        err
);
  asm_state_e state, nstate;
  logic [1:0] cnt;
  logic       accept;
  logic       abort;
  logic [NUM_LANES-1:0][LANE_W-1:0] ir_q;

  always_comb begin
    nstate     = state;
    byte_ready = 1'b0;
    byte_sel   = 4'b0000;
    accept     = 1'b0;
    case (state)
      COLLECT: begin
        byte_ready = 1'b1;
        if (byte_valid) begin
          accept   = 1'b1;
          byte_sel = 4'b0001 << cnt;
          if (cnt == 2'd3) nstate = HOLD;
        end
      end
      HOLD: begin
        if (ir_ready) nstate = COLLECT;
      end
      default: nstate = COLLECT;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state <= COLLECT;
      cnt   <= 2'd0;
    end else begin
      state <= nstate;
      if (abort)       cnt <= 2'd0;
      else if (accept) cnt <= cnt + 2'd1;
    end
  end

  // Each lane only ever loads from its own strobe, so stale lanes are simply
  // overwritten by the next word; ir_out never changes while in HOLD.
  for (genvar g = 0; g < NUM_LANES; g++) begin : g_lane
    always_ff @(posedge clk) begin
      if (rst)              ir_q[g] <= '0;
      else if (byte_sel[g]) ir_q[g] <= byte_in;
    end
  end

  assign ir_out   = ir_q;
  assign ir_valid = (state == HOLD);

`ifdef IR_BYTE_TIMEOUT_EN
  logic [7:0] idle;
  logic       err_q;

  // An accepted byte on the timeout cycle beats the abort.
  assign abort = (state == COLLECT) && (cnt != 2'd0) && !accept &&
                 (idle == 8'(TIMEOUT_CYC));

  always_ff @(posedge clk) begin
    if (rst) begin
      idle  <= 8'd0;
      err_q <= 1'b0;
    end else begin
      err_q <= abort;
      if (state != COLLECT || cnt == 2'd0 || accept || abort) idle <= 8'd0;
      else                                                    idle <= idle + 8'd1;
    end
  end

  assign err = err_q;
`else
  assign abort = 1'b0;
  assign err   = 1'b0;
`endif

  ir_field_decode #(.OPCODE_R(OPCODE_R)) u_dec (
    .ir       (ir_out),
    .rs1      (rs1),
    .rs2      (rs2),
    .rd       (rd),
    .alu_ctrl (alu_ctrl),
    .is_rtype (is_rtype)
  );
endmodule

// File: tb/tb_ir_byte_assembler.sv
// Bench for ir_byte_assembler: directed word scenarios plus random traffic,
// all checked every cycle against a queue-based model of the byte stream.
module tb_ir_byte_assembler;
`ifdef IR_BYTE_TIMEOUT_EN
  localparam int TO = 4;
`else
  localparam int TO = 16;
`endif

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic [7:0]  byte_in = 8'h00;
  logic        byte_valid = 1'b0;
  logic        byte_ready;
  logic [3:0]  byte_sel;
  logic [31:0] ir_out;
  logic        ir_valid;
  logic        ir_ready = 1'b0;
  logic [4:0]  rs1, rs2, rd;
  logic [5:0]  alu_ctrl;
  logic        is_rtype;
  logic        err;

  int tests = 0;
  int fails = 0;

  ir_byte_assembler #(.OPCODE_R(6'b000000), .TIMEOUT_CYC(TO)) dut (
    .clk(clk), .rst(rst), .byte_in(byte_in), .byte_valid(byte_valid),
    .byte_ready(byte_ready), .byte_sel(byte_sel), .ir_out(ir_out),
    .ir_valid(ir_valid), .ir_ready(ir_ready), .rs1(rs1), .rs2(rs2), .rd(rd),
    .alu_ctrl(alu_ctrl), .is_rtype(is_rtype), .err(err)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %h, expected %h at %0t", name, act, exp, $time);
    end
  endtask

  // Model: bytes collected so far, the word being held, and the words delivered.
  logic [7:0]  mq[$];
  bit          m_hold = 0;
  logic [31:0] m_word = 0;
  bit          m_err = 0;
  int          m_idle = 0;
  logic [31:0] delivered[$];

  always @(negedge clk) begin
    logic [3:0] esel;
    bit         abort;
    if (rst) begin
      mq.delete();
      m_hold = 0;
      m_word = 0;
      m_err  = 0;
      m_idle = 0;
    end else begin
      esel = (!m_hold && byte_valid) ? 4'(1 << mq.size()) : 4'b0000;
      chk("byte_ready", {31'b0, byte_ready}, {31'b0, !m_hold});
      chk("byte_sel", {28'b0, byte_sel}, {28'b0, esel});
      chk("ir_valid", {31'b0, ir_valid}, {31'b0, m_hold});
      chk("err", {31'b0, err}, {31'b0, m_err});
      if (m_hold) begin
        chk("ir_out", ir_out, m_word);
        chk("rs1", {27'b0, rs1}, {27'b0, m_word[25:21]});
        chk("rs2", {27'b0, rs2}, {27'b0, m_word[20:16]});
        chk("rd", {27'b0, rd}, {27'b0, m_word[15:11]});
        chk("alu_ctrl", {26'b0, alu_ctrl}, {26'b0, m_word[5:0]});
        chk("is_rtype", {31'b0, is_rtype}, {31'b0, m_word[31:26] == 6'd0});
      end
      // Predict the effect of the coming edge.
      abort = 0;
`ifdef IR_BYTE_TIMEOUT_EN
      if (!m_hold && mq.size() > 0 && !byte_valid) begin
        if (m_idle == TO) begin
          abort = 1;
          m_idle = 0;
        end else m_idle++;
      end else m_idle = 0;
`endif
      m_err = abort;
      if (abort) mq.delete();
      else if (!m_hold && byte_valid) begin
        mq.push_back(byte_in);
        if (mq.size() == 4) begin
          m_word = {mq[3], mq[2], mq[1], mq[0]};
          m_hold = 1;
          mq.delete();
        end
      end else if (m_hold && ir_ready) begin
        m_hold = 0;
        delivered.push_back(m_word);
      end
    end
  end

  task automatic step(input logic v, input logic [7:0] b, input logic rdy);
    @(posedge clk);
    #1;
    byte_valid = v;
    byte_in    = b;
    ir_ready   = rdy;
    #1;
  endtask

  logic [7:0] w1[4] = '{8'h20, 8'h18, 8'h22, 8'h00};
  logic [7:0] w2[4] = '{8'h11, 8'h22, 8'h33, 8'h44};
  logic [7:0] w3[4] = '{8'h55, 8'h66, 8'h77, 8'h8C};
  logic [7:0] w4[4] = '{8'hA1, 8'hB2, 8'hC3, 8'h04};

  initial begin
    repeat (2) @(posedge clk);
    #1 rst = 1'b0;
    #1;
    chk("rst_ir_valid", {31'b0, ir_valid}, 32'd0);
    chk("rst_ir_out", ir_out, 32'h0);
    chk("rst_byte_ready", {31'b0, byte_ready}, 32'd1);
    chk("rst_err", {31'b0, err}, 32'd0);

    // Back-to-back word with downstream always ready.
    for (int i = 0; i < 4; i++) begin
      step(1'b1, w1[i], 1'b1);
      chk("t1_sel", {28'b0, byte_sel}, 32'(1 << i));
    end
    step(1'b0, 8'h00, 1'b1);
    chk("t1_valid", {31'b0, ir_valid}, 32'd1);
    chk("t1_word", ir_out, 32'h00221820);
    chk("t1_rs1", {27'b0, rs1}, 32'd1);
    chk("t1_rs2", {27'b0, rs2}, 32'd2);
    chk("t1_rd", {27'b0, rd}, 32'd3);
    chk("t1_alu", {26'b0, alu_ctrl}, 32'h20);
    chk("t1_rtype", {31'b0, is_rtype}, 32'd1);
    step(1'b0, 8'h00, 1'b1);
    chk("t1_fall", {31'b0, ir_valid}, 32'd0);

    // Downstream stalls 6 cycles while the source keeps offering a byte.
    for (int i = 0; i < 4; i++) step(1'b1, w2[i], 1'b0);
    for (int i = 0; i < 6; i++) begin
      step(1'b1, w3[0], 1'b0);
      chk("t2_hold_valid", {31'b0, ir_valid}, 32'd1);
      chk("t2_hold_word", ir_out, 32'h44332211);
      chk("t2_hold_ready", {31'b0, byte_ready}, 32'd0);
    end
    step(1'b1, w3[0], 1'b1);
    step(1'b1, w3[0], 1'b0);
    chk("t2_restart_sel", {28'b0, byte_sel}, 32'd1);
    for (int i = 1; i < 4; i++) step(1'b1, w3[i], 1'b0);
    step(1'b0, 8'h00, 1'b0);
    chk("t6_word", ir_out, 32'h8C776655);
    chk("t6_rtype", {31'b0, is_rtype}, 32'd0);
    step(1'b0, 8'h00, 1'b1);

    // Three-cycle gaps between bytes.
    for (int i = 0; i < 4; i++) begin
      step(1'b1, w4[i], 1'b0);
      if (i < 3) repeat (3) step(1'b0, 8'h00, 1'b0);
    end
    step(1'b0, 8'h00, 1'b0);
    chk("t3_word", ir_out, 32'h04C3B2A1);
    chk("t3_err", {31'b0, err}, 32'd0);
    step(1'b0, 8'h00, 1'b1);

    // Reset mid-word discards collected lanes.
    step(1'b1, 8'hEE, 1'b0);
    step(1'b1, 8'hDD, 1'b0);
    @(posedge clk); #1 rst = 1'b1; byte_valid = 1'b0;
    @(posedge clk); #1 rst = 1'b0;
    for (int i = 0; i < 4; i++) step(1'b1, 8'(i + 1), 1'b0);
    step(1'b0, 8'h00, 1'b0);
    chk("t4_word", ir_out, 32'h04030201);
    step(1'b0, 8'h00, 1'b1);

`ifdef IR_BYTE_TIMEOUT_EN
    // One byte, then idle until the abort: err is a single-cycle pulse.
    step(1'b1, 8'h99, 1'b0);
    for (int i = 0; i < 5; i++) step(1'b0, 8'h00, 1'b0);
    step(1'b0, 8'h00, 1'b0);
    chk("t5_err_pulse", {31'b0, err}, 32'd1);
    step(1'b0, 8'h00, 1'b0);
    chk("t5_err_once", {31'b0, err}, 32'd0);
    for (int i = 0; i < 4; i++) step(1'b1, 8'(8'h10 + i), 1'b0);
    step(1'b0, 8'h00, 1'b0);
    chk("t5_clean_word", ir_out, 32'h13121110);
    step(1'b0, 8'h00, 1'b1);
    // A byte landing exactly on the timeout cycle wins.
    step(1'b1, 8'h41, 1'b0);
    for (int i = 0; i < TO; i++) step(1'b0, 8'h00, 1'b0);
    step(1'b1, 8'h42, 1'b0);
    chk("t5_race_sel", {28'b0, byte_sel}, 32'd2);
    step(1'b0, 8'h00, 1'b0);
    chk("t5_race_err", {31'b0, err}, 32'd0);
    step(1'b1, 8'h43, 1'b0);
    step(1'b1, 8'h44, 1'b0);
    step(1'b0, 8'h00, 1'b0);
    chk("t5_race_word", ir_out, 32'h44434241);
    step(1'b0, 8'h00, 1'b1);
`endif

    // Random traffic with occasional resets and long gaps.
    for (int i = 0; i < 3000; i++) begin
      step(($urandom_range(0, 9) < 5) ? 1'b1 : 1'b0, 8'($urandom),
           ($urandom_range(0, 9) < 4) ? 1'b1 : 1'b0);
      if ($urandom_range(0, 299) == 0) begin
        rst = 1'b1;
        @(posedge clk); #1 rst = 1'b0;
      end
      if ($urandom_range(0, 99) == 0) begin
        byte_valid = 1'b0;
        repeat ($urandom_range(1, 25)) @(posedge clk);
      end
    end

    chk("first_delivered", (delivered.size() > 0) ? delivered[0] : 32'hxxxxxxxx, 32'h00221820);
    @(negedge clk);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
